seg_scan_counter: RTL and testbench

Parametrised successor to the fixed four-cell timer display: an N-digit BCD up/down counter with load, enable and wrap flag, driving a time-multiplexed common-anode seven-segment display with anti-ghosting blanking, per-digit decimal points and optional leading-zero suppression. It replaces the separate timer, decode and scan chain at the display top level and produces the same packed `seg` bus: segments in the low byte, digit enables above.

---
 rtl/seg_scan_counter.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_counter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_counter.sv
// N-digit BCD up/down counter with load, driving a registered, time-multiplexed
// common-anode seven-segment scan with per-slot blanking and leading-zero suppression.
module seg_scan_counter #(
    parameter int NUMCELLS = 4,
    parameter int TICK_DIV = 1200000,
    parameter int SCAN_DIV = 3000,
    parameter int BLANK    = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*NUMCELLS-1:0] load_val,
    input  logic                  blank_lz,
    input  logic [NUMCELLS-1:0]   dp_mask,
    output logic [4*NUMCELLS-1:0] count,
    output logic                  wrap,
    output logic [NUMCELLS+7:0]   seg
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUMCELLS > 1) ? $clog2(NUMCELLS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUMCELLS - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK);

    logic [TW-1:0]         r_tickCnt;
    logic [SW-1:0]         r_scanCnt;
    logic [IW-1:0]         r_idx;
    logic [4*NUMCELLS-1:0] r_count;
    logic                  r_wrap;
    logic [NUMCELLS+7:0]   r_seg;

    logic                  w_step;
    logic [4*NUMCELLS-1:0] w_countInc;
    logic [4*NUMCELLS-1:0] w_countDec;
    logic [4*NUMCELLS-1:0] w_loadClamp;
    logic                  w_carry;
    logic                  w_borrow;
    logic                  w_allNine;
    logic                  w_allZero;
    logic [NUMCELLS-1:0]   w_blanked;
    logic                  w_zeroAbove;
    logic [3:0]            w_digit;
    logic                  w_dpOn;
    logic                  w_digitBlank;
    logic [NUMCELLS-1:0]   w_enables;
    logic [NUMCELLS+7:0]   w_segNext;

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        case (d)
            4'd0:    decodeDigit = 7'h3F;
            4'd1:    decodeDigit = 7'h06;
            4'd2:    decodeDigit = 7'h5B;
            4'd3:    decodeDigit = 7'h4F;
            4'd4:    decodeDigit = 7'h66;
            4'd5:    decodeDigit = 7'h6D;
            4'd6:    decodeDigit = 7'h7D;
            4'd7:    decodeDigit = 7'h07;
            4'd8:    decodeDigit = 7'h7F;
            4'd9:    decodeDigit = 7'h6F;
            default: decodeDigit = 7'h00;
        endcase
    endfunction

    assign w_step = en && (r_tickCnt == TICK_LAST);

    // Decimal successor, predecessor and clamped load value, rippling digit by digit.
    always_comb begin
        w_countInc  = r_count;
        w_countDec  = r_count;
        w_loadClamp = load_val;
        w_carry     = 1'b1;
        w_borrow    = 1'b1;
        w_allNine   = 1'b1;
        w_allZero   = 1'b1;
        for (int i = 0; i < NUMCELLS; i++) begin
            if (r_count[4*i +: 4] != 4'd9) w_allNine = 1'b0;
            if (r_count[4*i +: 4] != 4'd0) w_allZero = 1'b0;
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_countInc[4*i +: 4] = 4'd0;
                end else begin
                    w_countInc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_countDec[4*i +: 4] = 4'd9;
                end else begin
                    w_countDec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) w_loadClamp[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_tickCnt <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_count   <= w_loadClamp;
                r_tickCnt <= '0;
            end else if (w_step) begin
                r_tickCnt <= '0;
                r_count   <= up ? w_countInc : w_countDec;
                r_wrap    <= up ? w_allNine : w_allZero;
            end else if (en) begin
                r_tickCnt <= r_tickCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_scanCnt <= '0;
            r_idx     <= '0;
        end else if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    // A digit is leading-zero blanked when it and every digit above it are zero.
    always_comb begin
        w_blanked   = '0;
        w_zeroAbove = 1'b1;
        for (int i = NUMCELLS - 1; i > 0; i--) begin
            if (r_count[4*i +: 4] != 4'd0) w_zeroAbove = 1'b0;
            w_blanked[i] = blank_lz && w_zeroAbove;
        end
        w_digit      = r_count[3:0];
        w_dpOn       = dp_mask[0];
        w_digitBlank = 1'b0;
        for (int i = 0; i < NUMCELLS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit      = r_count[4*i +: 4];
                w_dpOn       = dp_mask[i];
                w_digitBlank = w_blanked[i];
            end
        end
        w_enables = '1;
        if ((r_scanCnt >= BLANK_END) && !w_digitBlank) w_enables[r_idx] = 1'b0;
        w_segNext = {w_enables, ~(w_dpOn && !w_digitBlank), ~decodeDigit(w_digit)};
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) r_seg <= '1;
        else     r_seg <= w_segNext;
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign seg   = r_seg;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Randomised and directed bench for seg_scan_counter, checked every cycle against an
// arithmetic model of the counter value and scan position.
module tb_seg_scan_counter;
    localparam int NUMCELLS = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int MAXV     = 10000;
    localparam int PERIOD   = NUMCELLS * SCAN_DIV;

    logic        clock;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [15:0] count;
    logic        wrap;
    logic [11:0] seg;

    int   testsRun  = 0;
    int   failCount = 0;
    logic checkEn   = 1'b0;

    int          mCount;
    int          mTick;
    int          mScan;
    logic        mWrap;
    logic [11:0] mSeg;

    seg_scan_counter #(
        .NUMCELLS(NUMCELLS),
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV),
        .BLANK(BLANK)
    ) dut (
        .clock(clock),
        .rst(rst),
        .en(en),
        .up(up),
        .load(load),
        .load_val(load_val),
        .blank_lz(blank_lz),
        .dp_mask(dp_mask),
        .count(count),
        .wrap(wrap),
        .seg(seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] b;
        for (int i = 0; i < NUMCELLS; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    function automatic int loadValue(input logic [15:0] lv);
        int v = 0;
        for (int i = 0; i < NUMCELLS; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    function automatic logic [11:0] modelSeg(input int v, input int pos, input logic blz,
                                             input logic [3:0] dpm);
        int         idx     = pos / SCAN_DIV;
        int         slot    = pos % SCAN_DIV;
        logic       blanked = blz && (idx > 0) && (v < pow10(idx));
        logic [3:0] ens     = 4'hF;
        if (slot >= BLANK && !blanked) ens[idx] = 1'b0;
        return {ens, !(dpm[idx] && !blanked), ~glyph((v / pow10(idx)) % 10)};
    endfunction

    // Model: counter value as an integer, scan position as one cycle index over the refresh period.
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            mCount = 0;
            mTick  = 0;
            mScan  = 0;
            mWrap  = 1'b0;
            mSeg   = 12'hFFF;
        end else begin
            mSeg  = modelSeg(mCount, mScan, blank_lz, dp_mask);
            mWrap = 1'b0;
            if (load) begin
                mCount = loadValue(load_val);
                mTick  = 0;
            end else if (en) begin
                if (mTick == TICK_DIV - 1) begin
                    mTick = 0;
                    if (up) begin
                        mWrap  = (mCount == MAXV - 1);
                        mCount = (mCount + 1) % MAXV;
                    end else begin
                        mWrap  = (mCount == 0);
                        mCount = (mCount + MAXV - 1) % MAXV;
                    end
                end else begin
                    mTick = mTick + 1;
                end
            end
            mScan = (mScan + 1) % PERIOD;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iEn, input logic iUp, input logic iLoad,
                                 input logic [15:0] iVal, input logic iBlz,
                                 input logic [3:0] iDp);
        en       = iEn;
        up       = iUp;
        load     = iLoad;
        load_val = iVal;
        blank_lz = iBlz;
        dp_mask  = iDp;
    endtask

    task automatic waitForEnables(input logic [3:0] pat, output int n);
        n = 0;
        while (seg[11:8] != pat && n < 64) begin
            @(negedge clock);
            n++;
        end
    endtask

    always @(negedge clock) begin
        if (checkEn && !rst) begin
            checkOutput("model_count", 32'(count), 32'(toBcd(mCount)));
            checkOutput("model_wrap", 32'(wrap), 32'(mWrap));
            checkOutput("model_seg", 32'(seg), 32'(mSeg));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int          hits;
        logic        rUp;
        logic        rBlz;
        logic [3:0]  rDp;
        logic [15:0] v;

        rst = 1'b1;
        applyStimulus(0, 1, 0, 16'h0000, 0, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("reset_seg", 32'(seg), 32'h0FFF);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_wrap", 32'(wrap), 32'h0);
        rst     = 1'b0;
        checkEn = 1'b1;

        applyStimulus(1, 1, 0, 16'h0000, 0, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("first_hold", 32'(count), 32'h0000);
        @(negedge clock);
        checkOutput("first_step", 32'(count), 32'h0001);
        repeat (4) @(negedge clock);
        checkOutput("second_step", 32'(count), 32'h0002);
        checkOutput("no_wrap", 32'(wrap), 32'h0);

        applyStimulus(0, 1, 1, 16'h9998, 0, 4'h0);
        @(negedge clock);
        checkOutput("load_9998", 32'(count), 32'h9998);
        applyStimulus(1, 1, 0, 16'h0000, 0, 4'h0);
        repeat (4) @(negedge clock);
        checkOutput("up_9999", 32'(count), 32'h9999);
        repeat (4) @(negedge clock);
        checkOutput("up_wrap_count", 32'(count), 32'h0000);
        checkOutput("up_wrap_pulse", 32'(wrap), 32'h1);
        @(negedge clock);
        checkOutput("up_wrap_drop", 32'(wrap), 32'h0);
        applyStimulus(1, 0, 0, 16'h0000, 0, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("down_wrap_count", 32'(count), 32'h9999);
        checkOutput("down_wrap_pulse", 32'(wrap), 32'h1);

        applyStimulus(0, 1, 1, 16'h0A3F, 0, 4'h0);
        @(negedge clock);
        checkOutput("load_clamp", 32'(count), 32'h0939);
        applyStimulus(1, 1, 0, 16'h0000, 0, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("tick_restart_hold", 32'(count), 32'h0939);
        @(negedge clock);
        checkOutput("tick_restart_step", 32'(count), 32'h0940);
        repeat (3) @(negedge clock);
        applyStimulus(1, 1, 1, 16'h1234, 0, 4'h0);
        @(negedge clock);
        checkOutput("load_beats_step", 32'(count), 32'h1234);
        checkOutput("load_no_wrap", 32'(wrap), 32'h0);
        applyStimulus(1, 1, 0, 16'h0000, 0, 4'h0);
        repeat (3) @(negedge clock);
        checkOutput("post_load_hold", 32'(count), 32'h1234);
        @(negedge clock);
        checkOutput("post_load_step", 32'(count), 32'h1235);
        repeat (3) @(negedge clock);
        applyStimulus(0, 1, 0, 16'h0000, 0, 4'h0);
        repeat (5) @(negedge clock);
        checkOutput("en_drop_terminal", 32'(count), 32'h1235);
        applyStimulus(1, 1, 0, 16'h0000, 0, 4'h0);
        @(negedge clock);
        checkOutput("en_resume_step", 32'(count), 32'h1236);

        applyStimulus(0, 1, 1, 16'h1234, 0, 4'h0);
        @(negedge clock);
        applyStimulus(0, 1, 0, 16'h1234, 0, 4'h0);
        repeat (2) @(negedge clock);
        waitForEnables(4'b0111, n);
        checkOutput("scan_find_d3", 32'(n < 64), 32'h1);
        checkOutput("scan_d3_glyph", 32'(seg[7:0]), 32'hF9);
        waitForEnables(4'b1111, n);
        waitForEnables(4'b1110, n);
        checkOutput("scan_blank_len", 32'(n), 32'd2);
        checkOutput("scan_d0_glyph", 32'(seg[7:0]), 32'h99);
        waitForEnables(4'b1111, n);
        checkOutput("scan_on_len", 32'(n), 32'd6);
        waitForEnables(4'b1101, n);
        checkOutput("scan_next_d1", 32'(n), 32'd2);

        applyStimulus(0, 1, 1, 16'h0007, 1, 4'b0100);
        @(negedge clock);
        applyStimulus(0, 1, 0, 16'h0007, 1, 4'b0100);
        repeat (2) @(negedge clock);
        hits = 0;
        n    = 0;
        for (int c = 0; c < PERIOD; c++) begin
            if (seg[11:9] != 3'b111 || seg[7] == 1'b0) hits++;
            if (seg[8] == 1'b0) n++;
            @(negedge clock);
        end
        checkOutput("lz_upper_dark", 32'(hits), 32'd0);
        checkOutput("lz_d0_on_cycles", 32'(n), 32'd6);
        waitForEnables(4'b1110, n);
        checkOutput("lz_d0_glyph", 32'(seg[7:0]), 32'hF8);
        applyStimulus(0, 1, 1, 16'h0000, 1, 4'b0100);
        @(negedge clock);
        applyStimulus(0, 1, 0, 16'h0000, 1, 4'b0100);
        repeat (2) @(negedge clock);
        waitForEnables(4'b1110, n);
        checkOutput("lz_zero_glyph", 32'(seg[7:0]), 32'hC0);

        @(negedge clock);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_seg", 32'(seg), 32'h0FFF);
        checkOutput("async_wrap", 32'(wrap), 32'h0);
        checkOutput("async_count", 32'(count), 32'h0);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("restart_blank", 32'(seg[11:8]), 32'hF);
        repeat (2) @(negedge clock);
        checkOutput("restart_d0", 32'(seg[11:8]), 32'hE);

        rUp  = 1'b1;
        rBlz = 1'b0;
        rDp  = 4'h0;
        for (int c = 0; c < 900; c++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom);
                1:       v = 16'h9997;
                2:       v = 16'h0002;
                default: v = 16'h0100;
            endcase
            if ($urandom_range(0, 39) == 0) rUp = !rUp;
            if ($urandom_range(0, 59) == 0) rBlz = !rBlz;
            if ($urandom_range(0, 29) == 0) rDp = 4'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, rUp, $urandom_range(0, 24) == 0,
                          v, rBlz, rDp);
            @(negedge clock);
            if (c == 450) begin
                #2 rst = 1'b1;
                @(negedge clock);
                rst = 1'b0;
            end
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
